sram_host_ctrl: RTL

- Upstream command stage for sram_top.
- Accepts parallel word-level write/read commands over a valid/ready handshake.
- Sequences the sram_top serial-load protocol (serial_in/shift/load/w_en/r_en/addr).
- Captures read data on data_valid and returns it over a valid/ready response channel, replacing bench-side full_write/full_read sequencing in system use.

---
 rtl/sram_host_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sram_host_ctrl.sv
// rtl/sram_host_ctrl.sv - word-level command front end sequencing the sram_top serial-load protocol
// Optional read timeout: define SRAM_RD_TIMEOUT_EN.
module sram_host_ctrl #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int TIMEOUT = 15,
    localparam int AW     = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [COLS-1:0] cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy,
    output logic            serial_in,
    output logic            shift,
    output logic            load,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out
);

    localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [IW-1:0] LAST = IW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_LOAD, S_WRITE, S_READ, S_WAIT, S_RESP
    } state_t;

    state_t          state, next_state;
    logic [IW-1:0]   bit_i, bit_i_d;
    logic [COLS-1:0] wdata_q, wsrc;
    logic            serial_d, shift_d, load_d, w_en_d, r_en_d, rsp_valid_d;
    logic            accept, rd_phase, timed_out;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign rd_phase  = (state == S_READ) || (state == S_WAIT);

`ifdef SRAM_RD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign timed_out = rd_phase & ~data_valid & (wait_cnt == CW'(TIMEOUT - 1));
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!rd_phase)
                wait_cnt <= '0;
            else if (!data_valid)
                wait_cnt <= wait_cnt + 1'b1;
            if (timed_out)
                err_q <= 1'b1;
            else if (state == S_RESP && rsp_ready)
                err_q <= 1'b0;
        end
    end
`else
    assign timed_out = (TIMEOUT < 0);
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_i     <= '0;
            wdata_q   <= '0;
            addr      <= '0;
            serial_in <= 1'b0;
            shift     <= 1'b0;
            load      <= 1'b0;
            w_en      <= 1'b0;
            r_en      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= next_state;
            bit_i     <= bit_i_d;
            serial_in <= serial_d;
            shift     <= shift_d;
            load      <= load_d;
            w_en      <= w_en_d;
            r_en      <= r_en_d;
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                addr    <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (rd_phase && data_valid)
                rsp_rdata <= data_out;
            else if (timed_out)
                rsp_rdata <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:         if (cmd_valid) next_state = cmd_write ? S_SHIFT : S_READ;
            S_SHIFT:        if (bit_i == LAST) next_state = S_LOAD;
            S_LOAD:         next_state = S_WRITE;
            S_WRITE:        next_state = S_IDLE;
            S_READ, S_WAIT: next_state = (data_valid || timed_out) ? S_RESP : S_WAIT;
            S_RESP:         if (rsp_ready) next_state = S_IDLE;
            default:        next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded from next_state so each one is a clean flop output aligned to its state.
    always_comb begin
        bit_i_d     = (state == S_SHIFT) ? bit_i + 1'b1 : '0;
        wsrc        = (state == S_IDLE) ? cmd_wdata : wdata_q;
        serial_d    = (next_state == S_SHIFT) & wsrc[LAST - bit_i_d];
        shift_d     = (next_state == S_SHIFT);
        load_d      = (next_state == S_LOAD);
        w_en_d      = (next_state == S_WRITE);
        r_en_d      = (next_state == S_READ);
        rsp_valid_d = (next_state == S_RESP);
    end

endmodule
